// File: rtl/mem_arbiter_if.sv
// Requester/ram bundle for mem_arbiter: master = requesters + ram, slave = arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              grant_id;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ack, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata,
    input  busy, grant_id
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ack, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata,
    output busy, grant_id
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for a single-port ram; 4-cycle transactions, ack at E+3.
// Optional MEM_ARB_ROUND_ROBIN_EN: ties alternate; otherwise port 1 always wins ties.
module mem_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic         clk,
  input  logic         reset_bar,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              grant_q, grant_d;
  logic              p0_ack_q, p0_ack_d;
  logic              p1_ack_q, p1_ack_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              win_p1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_q=1 means port 1 won the previous grant, so port 0 takes the next tie.
  logic last_q, last_d;

  assign win_p1 = bus.p1_req && (!bus.p0_req || !last_q);

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && (bus.p0_req || bus.p1_req)) begin
      last_d = win_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign win_p1 = bus.p1_req;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    grant_d    = grant_q;
    p0_ack_d   = 1'b0;
    p1_ack_d   = 1'b0;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.p0_req || bus.p1_req) begin
          grant_d = win_p1;
          addr_d  = win_p1 ? bus.p1_addr  : bus.p0_addr;
          wdata_d = win_p1 ? bus.p1_wdata : bus.p0_wdata;
          we_d    = win_p1 ? bus.p1_we    : bus.p0_we;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        // ram output is valid this cycle; writes leave the port's rdata untouched.
        if (!we_q) begin
          if (grant_q) p1_rdata_d = bus.mem_rdata;
          else         p0_rdata_d = bus.mem_rdata;
        end
        if (grant_q) p1_ack_d = 1'b1;
        else         p0_ack_d = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      grant_q    <= 1'b0;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      grant_q    <= grant_d;
      p0_ack_q   <= p0_ack_d;
      p1_ack_q   <= p1_ack_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  // Gating with reset_bar drops a write whose ISSUE cycle coincides with reset.
  assign bus.mem_we    = (state_q == ISSUE) && we_q && reset_bar;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.p0_ack    = p0_ack_q;
  assign bus.p1_ack    = p1_ack_q;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_rdata  = p1_rdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.grant_id  = grant_q;

endmodule
